// File: rtl/apb_master_bridge_if.sv
// Command, response and APB4 bus signals of apb_master_bridge.
// master: the bridge's view; slave: the view of whatever drives and observes it.
interface apb_master_bridge_if #(
  parameter int ADDR_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [31:0]       cmd_wdata;
  logic [3:0]        cmd_strb;
  logic [2:0]        cmd_prot;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  logic [ADDR_W-1:0] paddr;
  logic [2:0]        pprot;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [31:0]       pwdata;
  logic [3:0]        pstrb;
  logic              pready;
  logic [31:0]       prdata;
  logic              pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready,
    output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready,
    input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_master_bridge.sv
// APB4 requester: one valid/ready command becomes one SETUP/ACCESS transfer, answered on rsp.
// Define APB_MASTER_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait cycles.
module apb_master_bridge #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  apb_master_bridge_if.master  bus,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t state;
  logic   timed_out;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_master_bridge: TIMEOUT_CYCLES must be at least 1");
  end

  assign bus.cmd_ready = (state == IDLE) && !rst;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
  // The edge that would count the TIMEOUT_CYCLES-th idle ACCESS cycle aborts instead.
  assign timed_out = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      busy          <= 1'b0;
      bus.psel      <= 1'b0;
      bus.penable   <= 1'b0;
      bus.pwrite    <= 1'b0;
      bus.paddr     <= '0;
      bus.pprot     <= '0;
      bus.pwdata    <= '0;
      bus.pstrb     <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_rdata <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_cnt      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            bus.paddr  <= bus.cmd_addr[ADDR_W-1:0];
            bus.pwrite <= bus.cmd_write;
            bus.pwdata <= bus.cmd_wdata;
            bus.pstrb  <= bus.cmd_write ? bus.cmd_strb : 4'h0;
            bus.pprot  <= bus.cmd_prot;
            bus.psel   <= 1'b1;
            busy       <= 1'b1;
            state      <= SETUP;
          end
        end
        SETUP: begin
          bus.penable <= 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
          wait_cnt    <= '0;
`endif
          state       <= ACCESS;
        end
        ACCESS: begin
          // pready wins over a timeout landing in the same cycle.
          if (bus.pready) begin
            bus.psel      <= 1'b0;
            bus.penable   <= 1'b0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= bus.pslverr;
            bus.rsp_rdata <= bus.pwrite ? 32'h0 : bus.prdata;
            state         <= RESP;
          end else if (timed_out) begin
            bus.psel      <= 1'b0;
            bus.penable   <= 1'b0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b1;
            bus.rsp_rdata <= 32'h0;
            state         <= RESP;
          end else begin
`ifdef APB_MASTER_TIMEOUT_EN
            wait_cnt <= wait_cnt + 1'b1;
`endif
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            busy          <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: transfer-level model checked every cycle
// plus directed scenarios with hand-computed literal expectations.
module tb_apb_master_bridge;

  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  int errors = 0;
  int checks = 0;

  apb_master_bridge_if #(.ADDR_W(32)) bus ();

  apb_master_bridge #(.ADDR_W(32), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Completer: pready after `waits` wait cycles, garbage prdata/pslverr while not ready.
  int          waits   = 0;
  bit          stuck   = 0;
  logic [31:0] rd_val  = '0;
  logic        err_val = 1'b0;
  int          acc_n   = 0;

  initial begin : completer
    bit rdy;
    bus.pready  = 1'b0;
    bus.prdata  = 32'hBADBAD00;
    bus.pslverr = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bus.psel && bus.penable) acc_n++;
      else acc_n = 0;
      rdy = !stuck && bus.psel && bus.penable && (acc_n > waits);
      bus.pready  = rdy;
      bus.prdata  = rdy ? rd_val : 32'hBADBAD00;
      bus.pslverr = rdy ? err_val : 1'b1;
    end
  end

  // Transfer-level model: one outstanding transfer, timestamps relative to its acceptance.
  bit          m_in_xfer = 0;
  bit          m_apb     = 0;
  bit          m_setup   = 0;
  bit          m_rv      = 0;
  logic        m_err     = 0;
  logic [31:0] m_rdata   = '0;
  logic [31:0] m_paddr   = '0;
  logic        m_pwrite  = 0;
  logic [31:0] m_pwdata  = '0;
  logic [3:0]  m_pstrb   = '0;
  logic [2:0]  m_pprot   = '0;
  int          m_waits   = 0;

  initial begin : model_compare
    forever begin
      @(posedge clk);
      if (rst) begin
        m_in_xfer = 0; m_apb = 0; m_setup = 0; m_rv = 0; m_err = 0; m_rdata = '0;
        m_paddr = '0; m_pwrite = 0; m_pwdata = '0; m_pstrb = '0; m_pprot = '0;
      end else if (!m_in_xfer) begin
        if (bus.cmd_valid) begin
          m_in_xfer = 1; m_apb = 1; m_setup = 1; m_waits = 0;
          m_paddr  = bus.cmd_addr;
          m_pwrite = bus.cmd_write;
          m_pwdata = bus.cmd_wdata;
          m_pstrb  = bus.cmd_write ? bus.cmd_strb : 4'h0;
          m_pprot  = bus.cmd_prot;
        end
      end else if (m_apb) begin
        if (m_setup) m_setup = 0;
        else if (bus.pready) begin
          m_apb = 0; m_rv = 1; m_err = bus.pslverr;
          m_rdata = m_pwrite ? 32'h0 : bus.prdata;
        end else begin
          m_waits++;
`ifdef APB_MASTER_TIMEOUT_EN
          if (m_waits == TIMEOUT) begin
            m_apb = 0; m_rv = 1; m_err = 1; m_rdata = 32'h0;
          end
`endif
        end
      end else if (bus.rsp_ready) begin
        m_rv = 0; m_in_xfer = 0;
      end

      @(negedge clk);
      check_output("m_cmd_ready", bus.cmd_ready, !rst && !m_in_xfer);
      check_output("m_busy",      busy,          m_in_xfer);
      check_output("m_psel",      bus.psel,      m_apb);
      check_output("m_penable",   bus.penable,   m_apb && !m_setup);
      check_output("m_rsp_valid", bus.rsp_valid, m_rv);
      if (m_rv) begin
        check_output("m_rsp_rdata", bus.rsp_rdata, m_rdata);
        check_output("m_rsp_err",   bus.rsp_err,   m_err);
      end
      if (m_apb) begin
        check_output("m_paddr",  bus.paddr,  m_paddr);
        check_output("m_pwrite", bus.pwrite, m_pwrite);
        check_output("m_pwdata", bus.pwdata, m_pwdata);
        check_output("m_pstrb",  bus.pstrb,  m_pstrb);
        check_output("m_pprot",  bus.pprot,  m_pprot);
      end
    end
  end

  task automatic apply_stimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] strb, input logic [2:0] prot);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    bus.cmd_strb  = strb;
    bus.cmd_prot  = prot;
  endtask

  // Returns #1 after the accepting edge.
  task automatic wait_accept();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        return;
      end
    end
    check_output("accept_timeout", 32'd1, 32'd0);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int pen, output logic [31:0] rd, output logic er);
    pen = 0; rd = 'x; er = 1'bx;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.penable) pen++;
      if (bus.rsp_valid && bus.rsp_ready) begin
        rd = bus.rsp_rdata;
        er = bus.rsp_err;
        @(posedge clk);
        #1;
        return;
      end
    end
    check_output("rsp_timeout", 32'd1, 32'd0);
  endtask

  int          pen;
  logic [31:0] rd;
  logic        er;
  int          cnt;

  initial begin
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0;
    bus.cmd_wdata = '0;   bus.cmd_strb = '0;    bus.cmd_prot = '0;
    bus.rsp_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("rst_psel",      bus.psel,      0);
    check_output("rst_penable",   bus.penable,   0);
    check_output("rst_rsp_valid", bus.rsp_valid, 0);
    check_output("rst_busy",      busy,          0);
    check_output("rst_cmd_ready", bus.cmd_ready, 0);
    check_output("rst_paddr",     bus.paddr,     0);
    check_output("rst_pwdata",    bus.pwdata,    0);
    check_output("rst_pstrb",     bus.pstrb,     0);
    check_output("rst_rsp_rdata", bus.rsp_rdata, 0);
    check_output("rst_rsp_err",   bus.rsp_err,   0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_output("idle_cmd_ready", bus.cmd_ready, 1);

    $display("[TB] write with zero wait states");
    waits = 0; err_val = 0;
    apply_stimulus(1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b010);
    wait_accept();
    @(negedge clk);
    check_output("t1_psel_n1",    bus.psel,    1);
    check_output("t1_penable_n1", bus.penable, 0);
    @(negedge clk);
    check_output("t1_penable_n2", bus.penable, 1);
    check_output("t1_pwrite",     bus.pwrite,  1);
    check_output("t1_pstrb",      bus.pstrb,   4'hF);
    check_output("t1_paddr",      bus.paddr,   32'h10);
    check_output("t1_pwdata",     bus.pwdata,  32'hDEADBEEF);
    @(negedge clk);
    check_output("t1_rsp_valid_n3", bus.rsp_valid, 1);
    check_output("t1_rsp_rdata",    bus.rsp_rdata, 0);
    check_output("t1_rsp_err",      bus.rsp_err,   0);
    check_output("t1_psel_n3",      bus.psel,      0);
    @(posedge clk); #1;

    $display("[TB] read with three wait states");
    waits = 3; rd_val = 32'h12345678;
    apply_stimulus(0, 32'h24, 32'hFFFF0000, 4'hF, 3'b000);
    wait_accept();
    wait_rsp(pen, rd, er);
    check_output("t2_penable_cycles", pen, 4);
    check_output("t2_rdata",          rd,  32'h12345678);
    check_output("t2_err",            er,  0);

    $display("[TB] read with slave error then clean write");
    waits = 0; rd_val = 32'hCAFEF00D; err_val = 1;
    apply_stimulus(0, 32'h30, 32'h0, 4'h0, 3'b001);
    wait_accept();
    wait_rsp(pen, rd, er);
    check_output("t3_err",   er, 1);
    check_output("t3_rdata", rd, 32'hCAFEF00D);
    err_val = 0;
    apply_stimulus(1, 32'h34, 32'h11223344, 4'h3, 3'b000);
    wait_accept();
    wait_rsp(pen, rd, er);
    check_output("t3_next_err",   er, 0);
    check_output("t3_next_rdata", rd, 0);

    $display("[TB] response backpressure with a pending command");
    bus.rsp_ready = 1'b0; rd_val = 32'hA5A5A5A5;
    apply_stimulus(0, 32'h40, 32'h0, 4'h0, 3'b000);
    wait_accept();
    apply_stimulus(1, 32'h44, 32'h55AA55AA, 4'hC, 3'b100);
    cnt = 0;
    while (!bus.rsp_valid && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    check_output("t4_rsp_seen", bus.rsp_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output("t4_hold_valid", bus.rsp_valid, 1);
      check_output("t4_hold_rdata", bus.rsp_rdata, 32'hA5A5A5A5);
      check_output("t4_cmd_ready",  bus.cmd_ready, 0);
      check_output("t4_psel",       bus.psel,      0);
    end
    @(posedge clk); #1 bus.rsp_ready = 1'b1;
    wait_accept();
    wait_rsp(pen, rd, er);
    check_output("t4_second_err",   er, 0);
    check_output("t4_second_rdata", rd, 0);

    $display("[TB] reset during ACCESS");
    waits = 5; rd_val = 32'h76543210;
    apply_stimulus(0, 32'h50, 32'h0, 4'h0, 3'b000);
    wait_accept();
    repeat (3) @(negedge clk);
    check_output("t5_in_access", bus.penable, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_output("t5_psel",      bus.psel,      0);
    check_output("t5_penable",   bus.penable,   0);
    check_output("t5_rsp_valid", bus.rsp_valid, 0);
    check_output("t5_busy",      busy,          0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_output("t5_cmd_ready_after", bus.cmd_ready, 1);
    waits = 0; rd_val = 32'h13579BDF;
    apply_stimulus(0, 32'h54, 32'h0, 4'h0, 3'b000);
    wait_accept();
    wait_rsp(pen, rd, er);
    check_output("t5_clean_rdata", rd, 32'h13579BDF);
    check_output("t5_clean_err",   er, 0);

    $display("[TB] completer never ready");
    stuck = 1; rd_val = 32'hFEEDFACE;
    apply_stimulus(0, 32'h60, 32'h0, 4'h0, 3'b000);
    wait_accept();
`ifdef APB_MASTER_TIMEOUT_EN
    wait_rsp(pen, rd, er);
    check_output("t6_penable_cycles", pen, TIMEOUT);
    check_output("t6_err",            er,  1);
    check_output("t6_rdata",          rd,  0);
    stuck = 0; waits = TIMEOUT - 1;
    apply_stimulus(0, 32'h64, 32'h0, 4'h0, 3'b000);
    wait_accept();
    wait_rsp(pen, rd, er);
    check_output("t6_limit_pen",   pen, TIMEOUT);
    check_output("t6_limit_err",   er,  0);
    check_output("t6_limit_rdata", rd,  32'hFEEDFACE);
`else
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.psel && bus.penable) cnt++;
    end
    check_output("t6_stays_in_access", cnt, 29);
    check_output("t6_no_rsp", bus.rsp_valid, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    stuck = 0;
    @(negedge clk);
    check_output("t6_recovered", bus.cmd_ready, 1);
`endif

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
